// File: rtl/pwm_fade_ctrl_if.sv
// Load handshake between a fade sequencer and its host: a target level set plus the step-rate divider.
interface pwm_fade_ctrl_if #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 3,
    parameter int DIV_WIDTH = 8
);
    logic                      load_valid;
    logic                      load_ready;
    logic [CHANNELS*WIDTH-1:0] load_target;
    logic [DIV_WIDTH-1:0]      load_div;

    modport master (
        output load_valid,
        output load_target,
        output load_div,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_target,
        input  load_div,
        output load_ready
    );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: ramps CHANNELS PWM levels by 1 LSB per step toward loaded targets, only at period boundaries.
// Optional abort input is enabled by defining PWM_FADE_ABORT_EN.
module pwm_fade_ctrl #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 3,
    parameter int DIV_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef PWM_FADE_ABORT_EN
    input  logic                      abort,
`endif
    pwm_fade_ctrl_if.slave            load,
    output logic [CHANNELS*WIDTH-1:0] level,
    output logic                      busy,
    output logic                      done,
    output logic                      frame_end
);
    typedef enum logic [0:0] {IDLE = 1'b0, FADE = 1'b1} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     cnt;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [DIV_WIDTH-1:0] div_lat;
    logic [WIDTH-1:0]     level_p0 [CHANNELS];
    logic [WIDTH-1:0]     target   [CHANNELS];
    logic                 ready;
    logic                 accept;
    logic                 step_en;
    logic                 div_reload;
    logic                 div_dec;
    logic                 div_clear;
    logic                 all_eq;
    logic                 abort_req;

    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] tgt);
        if (cur < tgt)
            return cur + WIDTH'(1);
        else if (cur > tgt)
            return cur - WIDTH'(1);
        return cur;
    endfunction

`ifdef PWM_FADE_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Free-running period counter, in lockstep with the PWM counters sharing clk/reset
    assign frame_end       = &cnt;
    assign load.load_ready = ready;

    always_comb begin
        all_eq = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (level_p0[i] != target[i])
                all_eq = 1'b0;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_level_out
        assign level[ch*WIDTH +: WIDTH] = level_p0[ch];
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        step_en    = 1'b0;
        div_reload = 1'b0;
        div_dec    = 1'b0;
        div_clear  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (load.load_valid) begin
                    accept    = 1'b1;
                    state_nxt = FADE;
                end
            end
            FADE: begin
                busy = 1'b1;
                // Abort wins over the boundary evaluation in the same cycle
                if (abort_req) begin
                    div_clear = 1'b1;
                    state_nxt = IDLE;
                end else if (frame_end) begin
                    if (all_eq) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end else if (div_cnt == '0) begin
                        step_en    = 1'b1;
                        div_reload = 1'b1;
                    end else begin
                        div_dec = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            div_cnt <= '0;
            div_lat <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                level_p0[i] <= '0;
                target[i]   <= '0;
            end
        end else begin
            cnt <= cnt + WIDTH'(1);
            if (accept) begin
                div_lat <= load.load_div;
                div_cnt <= load.load_div;
                for (int i = 0; i < CHANNELS; i++)
                    target[i] <= load.load_target[i*WIDTH +: WIDTH];
            end else if (div_clear) begin
                div_cnt <= '0;
            end else if (div_reload) begin
                div_cnt <= div_lat;
            end else if (div_dec) begin
                div_cnt <= div_cnt - DIV_WIDTH'(1);
            end
            // step_en only fires on frame_end, so the new level starts at PWM count 0
            if (step_en) begin
                for (int i = 0; i < CHANNELS; i++)
                    level_p0[i] <= step_toward(level_p0[i], target[i]);
            end
        end
    end
endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
Sequencer that drives the level inputs of a bank of PWM channels, for example the R/G/B channels of the mixer. It accepts a set of target levels through a valid/ready handshake. It then ramps each channel's level by 1 LSB per step toward its target, changing levels only at PWM period boundaries so that no period is ever truncated or glitched. It keeps an internal period counter that runs in lockstep with the PWM counters, because all of them share clk and reset.

Parameters:
WIDTH, 8, level and PWM counter width; one period is 2^WIDTH cycles.
CHANNELS, 3, number of PWM channels driven.
DIV_WIDTH, 8, width of the step-rate divider.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
load_valid  input  1  new target set offered
load_ready  output  1  controller can accept a target set
load_target  input  CHANNELS*WIDTH  target levels; channel n occupies bits [n*WIDTH +: WIDTH]
load_div  input  DIV_WIDTH  PWM periods per step, minus 1
level  output  CHANNELS*WIDTH  registered level to the PWM instances, same packing as load_target
busy  output  1  high while fading
done  output  1  one-cycle pulse when all channels reach their targets
frame_end  output  1  high on the last cycle of each PWM period

Behaviour:
Reset values (clk and reset: reset is synchronous, active-high; clock is clk):
- level = 0, targets = 0, period counter = 0, divider = 0.
- State = IDLE, so load_ready = 1, busy = 0, done = 0.

Period counter:
- WIDTH bits, increments every cycle, wraps from 2^WIDTH-1 to 0.
- frame_end = (counter == 2^WIDTH-1), combinational from the counter.
- Level registers update only on a frame_end cycle, so a new value takes effect from PWM counter 0.

States:
- IDLE: load_ready = 1. On load_valid && load_ready:
  - latch load_target and load_div;
  - set divider = load_div;
  - go to FADE on the next cycle.
- FADE: load_ready = 0, busy = 1. load_valid is ignored and the load_target/load_div inputs are don't-care. Each frame_end cycle is evaluated in this priority order:
  1. If every level equals its target: pulse done for that cycle, go to IDLE, no level change.
  2. Else if divider == 0: take a step and reload divider = latched div.
  3. Else: divider decrements.
  - Non-frame_end cycles hold all state.

Step rule:
- Per channel: level + 1 if level < target, level - 1 if level > target, else hold.
- Channels step independently and may finish at different steps.
- No overflow is possible, because a level never passes its target.

Timing:
- Step interval = (load_div + 1) PWM periods.
- The first step happens at the first frame_end after acceptance if load_div = 0.
- For a maximum per-channel distance D, done occurs at the frame_end D*(load_div+1)+1 frame_ends after acceptance. Frame_ends are counted from the one at or after the acceptance cycle +1.

Boundary cases:
- Acceptance on a frame_end cycle: that frame_end is not evaluated. FADE starts the following cycle.
- A target set equal to the current levels produces done at the first frame_end in FADE.
- done never coincides with load_ready in the same cycle; IDLE starts the cycle after done.
- Reset mid-fade: everything returns to reset values on the next edge, including level = 0 and the period counter = 0.

Optional Feature:
Macro PWM_FADE_ABORT_EN.
- When defined: adds input port abort (1 bit). abort high in FADE on any cycle:
  - freezes the levels at their current values;
  - clears the divider;
  - goes to IDLE on the next cycle, with no done pulse.
  - abort has priority over a simultaneous frame_end evaluation.
  - abort in IDLE has no effect.
- When undefined: the port is absent and a fade always runs to completion or reset.

Test Plan:
WIDTH=4, CHANNELS=3 (16-cycle period).
1. Reset, then hold 40 cycles: level = 0, load_ready = 1, busy = 0, frame_end high at cycles 15 and 31 after reset release.
2. Load targets {15,0,8} with div = 0 from level 0: ch0 increments once per period, ch2 stops at 8 after 8 steps, ch1 stays at 0. Levels change only on cycles following frame_end. done is pulsed once at the 16th evaluated frame_end, then load_ready = 1.
3. From {15,0,8}, load {12,3,8} with div = 2: levels change every 3rd frame_end to {14,1,8}, {13,2,8}, {12,3,8}. done occurs 10 frame_ends after acceptance.
4. load_valid asserted continuously during a fade with different data: no acceptance (load_ready = 0), and the targets are unchanged.
5. Load the current levels as targets: busy for one partial period, done at the first frame_end, no level change.
6. Reset asserted mid-fade at level {5,x,x}: the next cycle shows level = 0 and IDLE. With PWM_FADE_ABORT_EN defined: abort mid-fade freezes the levels, load_ready = 1 the next cycle, and done is never pulsed.
